// File: rtl/stage_memory_pkg.sv
// Shared types for the MEM stage: pipeline control bundles, access sizes, FSM states.
package stage_memory_pkg;

  typedef struct packed {
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] MemSize;
    logic       MemSignExtend;
  } MEM_Control_t;

  typedef struct packed {
    logic RegWrite;
    logic MemToReg;
  } WB_Control_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } RegisterIDs_t;

  localparam logic [1:0] MEMSIZE_B = 2'd0;
  localparam logic [1:0] MEMSIZE_H = 2'd1;
  localparam logic [1:0] MEMSIZE_W = 2'd2;

  typedef enum logic [1:0] {
    MEMSTATE_IDLE,
    MEMSTATE_REQ,
    MEMSTATE_WAIT_RD
  } mem_state_e;

endpackage

// File: rtl/stage_memory_if.sv
// Data bus between the MEM stage (master) and the data memory (slave).
interface stage_memory_if;
  logic        Valid;
  logic        Write;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [3:0]  ByteEnable;
  logic        Ready;
  logic        RValid;
  logic [31:0] RData;

  modport master (output Valid, Write, Addr, WData, ByteEnable,
                  input  Ready, RValid, RData);
  modport slave  (input  Valid, Write, Addr, WData, ByteEnable,
                  output Ready, RValid, RData);
endinterface

// File: rtl/stage_memory_align.sv
// Combinational lane steering: store data replication / byte enables and
// load data extraction with sign or zero extension.
module mem_align
  import stage_memory_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic [31:0] load_data_o
);

  logic [31:0] byte_shift;
  logic [15:0] half_sel;

  always_comb begin
    byte_shift  = rdata_i >> {addr_lo_i, 3'b000};
    half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wdata_o     = store_data_i;
    be_o        = 4'b1111;
    load_data_o = rdata_i;
    case (size_i)
      MEMSIZE_B: begin
        wdata_o     = {4{store_data_i[7:0]}};
        be_o        = 4'b0001 << addr_lo_i;
        load_data_o = {{24{sext_i & byte_shift[7]}}, byte_shift[7:0]};
      end
      // Halfwords steer on a[1] only; a[0] never moves the lane.
      MEMSIZE_H: begin
        wdata_o     = {2{store_data_i[15:0]}};
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        load_data_o = {{16{sext_i & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_memory.sv
// MEM stage of the RV32I pipeline: data bus FSM, stall generation, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse o_MisalignFault.
module stage_memory
  import stage_memory_pkg::*;
#(
  parameter int DBUS_TIMEOUT = 255
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  MEM_Control_t  i_MEM_Control,
  input  WB_Control_t   i_WB_Control,
  input  RegisterIDs_t  i_RegisterIDs,
  input  logic [31:0]   i_AluOutput,
  input  logic [31:0]   i_rs2Value,
  stage_memory_if.master dbus,
  output WB_Control_t   o_WB_Control,
  output RegisterIDs_t  o_RegisterIDs,
  output logic [31:0]   o_AluOutput,
  output logic [31:0]   o_MemData,
  output logic          o_Stall,
  output logic          o_BusError
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic          o_MisalignFault
`endif
);

  localparam int CNT_W = $clog2(DBUS_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(DBUS_TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  WB_Control_t      wb_q, wb_d;
  RegisterIDs_t     ids_q, ids_d;
  logic [31:0]      alu_q, alu_d, mdata_q, mdata_d;
  logic             berr_q;
  logic             req, stall, done, timeout;
  logic             mem_op, is_store, is_load, misalign;
  logic [31:0]      wdata, load_data;
  logic [3:0]       be;

  // Read+write together is a store.
  assign mem_op   = i_MEM_Control.MemRead | i_MEM_Control.MemWrite;
  assign is_store = i_MEM_Control.MemWrite;
  assign is_load  = i_MEM_Control.MemRead & ~i_MEM_Control.MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_op &
                    (((i_MEM_Control.MemSize == MEMSIZE_H) & i_AluOutput[0]) |
                     ((i_MEM_Control.MemSize == MEMSIZE_W) & (i_AluOutput[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  mem_align u_align (
    .size_i       (i_MEM_Control.MemSize),
    .sext_i       (i_MEM_Control.MemSignExtend),
    .addr_lo_i    (i_AluOutput[1:0]),
    .store_data_i (i_rs2Value),
    .rdata_i      (dbus.RData),
    .wdata_o      (wdata),
    .be_o         (be),
    .load_data_o  (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      MEMSTATE_IDLE: begin
        if (mem_op && !misalign) begin
          req = 1'b1;
          if (is_store && dbus.Ready) begin
            done = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = '0;
            state_d = (!is_store && dbus.Ready) ? MEMSTATE_WAIT_RD : MEMSTATE_REQ;
          end
        end else begin
          done = 1'b1;
        end
      end
      // Acceptance wins over a timeout landing in the same cycle.
      MEMSTATE_REQ: begin
        req   = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (dbus.Ready) begin
          if (is_store) begin
            done    = 1'b1;
            state_d = MEMSTATE_IDLE;
          end else begin
            stall   = 1'b1;
            cnt_d   = '0;
            state_d = MEMSTATE_WAIT_RD;
          end
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          done    = 1'b1;
          state_d = MEMSTATE_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      MEMSTATE_WAIT_RD: begin
        cnt_d = cnt_q + 1'b1;
        if (dbus.RValid) begin
          done    = 1'b1;
          state_d = MEMSTATE_IDLE;
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          done    = 1'b1;
          state_d = MEMSTATE_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = MEMSTATE_IDLE;
    endcase

    // Stall cycles emit a bubble; everything else holds until completion.
    wb_d          = wb_q;
    wb_d.RegWrite = 1'b0;
    ids_d         = ids_q;
    alu_d         = alu_q;
    mdata_d       = mdata_q;
    if (done) begin
      wb_d          = i_WB_Control;
      wb_d.RegWrite = i_WB_Control.RegWrite & ~misalign;
      ids_d         = i_RegisterIDs;
      alu_d         = i_AluOutput;
      mdata_d       = (is_load && !timeout && !misalign) ? load_data : 32'd0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= MEMSTATE_IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
      alu_q   <= '0;
      mdata_q <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      alu_q   <= alu_d;
      mdata_q <= mdata_d;
      berr_q  <= timeout;
    end
  end

  always_ff @(posedge i_Clock) begin
    ids_q <= ids_d;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic fault_q;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) fault_q <= 1'b0;
    else         fault_q <= misalign && (state_q == MEMSTATE_IDLE);
  end
  assign o_MisalignFault = fault_q;
`endif

  assign dbus.Valid      = req & ~i_Reset;
  assign dbus.Write      = is_store;
  assign dbus.Addr       = {i_AluOutput[31:2], 2'b00};
  assign dbus.WData      = wdata;
  assign dbus.ByteEnable = be;

  assign o_Stall       = stall;
  assign o_BusError    = berr_q;
  assign o_WB_Control  = wb_q;
  assign o_RegisterIDs = ids_q;
  assign o_AluOutput   = alu_q;
  assign o_MemData     = mdata_q;

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory; inputs change on the falling edge, outputs sampled there too.
module tb_stage_memory;
  import stage_memory_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  MEM_Control_t memc;
  WB_Control_t  wbc, wb_o;
  RegisterIDs_t ids, ids_o;
  logic [31:0]  alu, rs2, alu_o, mdata_o;
  logic         stall, berr;
`ifdef MEM_MISALIGN_TRAP_EN
  logic         mfault;
`endif

  stage_memory_if dbus();

  stage_memory #(.DBUS_TIMEOUT(4)) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_MEM_Control (memc),
    .i_WB_Control  (wbc),
    .i_RegisterIDs (ids),
    .i_AluOutput   (alu),
    .i_rs2Value    (rs2),
    .dbus          (dbus),
    .o_WB_Control  (wb_o),
    .o_RegisterIDs (ids_o),
    .o_AluOutput   (alu_o),
    .o_MemData     (mdata_o),
    .o_Stall       (stall),
    .o_BusError    (berr)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .o_MisalignFault (mfault)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int stalls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] d, input logic rw);
    memc = '{MemRead: rd, MemWrite: wr, MemSize: sz, MemSignExtend: sx};
    wbc  = '{RegWrite: rw, MemToReg: rd};
    ids  = '{rs1: 5'd1, rs2: 5'd2, rd: 5'd3};
    alu  = a;
    rs2  = d;
  endtask

  task automatic nop(input logic [31:0] a, input logic rw);
    op(1'b0, 1'b0, MEMSIZE_W, 1'b0, a, 32'd0, rw);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    nop(32'd0, 1'b0);
    dbus.Ready  = 1'b0;
    dbus.RValid = 1'b0;
    dbus.RData  = 32'd0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", dbus.Valid, 0);
    chk("rst_regwrite", wb_o.RegWrite, 0);
    chk("rst_buserr", berr, 0);
    chk("rst_memdata", mdata_o, 0);
    chk("rst_alu", alu_o, 0);

    // Plain ALU op flows through in one cycle.
    nop(32'h1234, 1'b1);
    #1;
    chk("alu_stall", stall, 0);
    chk("alu_valid", dbus.Valid, 0);
    tick();
    chk("alu_out", alu_o, 32'h1234);
    chk("alu_regwrite", wb_o.RegWrite, 1);

    // SB to byte 3.
    op(1'b0, 1'b1, MEMSIZE_B, 1'b0, 32'h103, 32'hAB, 1'b0);
    dbus.Ready = 1'b1;
    #1;
    chk("sb_valid", dbus.Valid, 1);
    chk("sb_write", dbus.Write, 1);
    chk("sb_addr", dbus.Addr, 32'h100);
    chk("sb_wdata", dbus.WData, 32'hABABABAB);
    chk("sb_be", dbus.ByteEnable, 4'b1000);
    chk("sb_stall", stall, 0);
    tick();
    chk("sb_regwrite", wb_o.RegWrite, 0);

    // SH to upper half.
    op(1'b0, 1'b1, MEMSIZE_H, 1'b0, 32'h112, 32'h12345678, 1'b0);
    #1;
    chk("sh_addr", dbus.Addr, 32'h110);
    chk("sh_wdata", dbus.WData, 32'h56785678);
    chk("sh_be", dbus.ByteEnable, 4'b1100);
    tick();

    // SW with Ready late by one cycle.
    op(1'b0, 1'b1, MEMSIZE_W, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0);
    dbus.Ready = 1'b0;
    #1;
    chk("sw_stall0", stall, 1);
    chk("sw_be", dbus.ByteEnable, 4'hF);
    chk("sw_wdata", dbus.WData, 32'hDEADBEEF);
    tick();
    dbus.Ready = 1'b1;
    #1;
    chk("sw_req_valid", dbus.Valid, 1);
    chk("sw_req_addr", dbus.Addr, 32'h20);
    chk("sw_req_stall", stall, 0);
    tick();
    dbus.Ready = 1'b0;
    nop(32'h55, 1'b1);
    #1;
    chk("sw_idle_valid", dbus.Valid, 0);
    chk("sw_idle_stall", stall, 0);
    tick();
    chk("sw_next_alu", alu_o, 32'h55);

    // Read and write both set behaves as a store.
    op(1'b1, 1'b1, MEMSIZE_B, 1'b0, 32'h2, 32'h5A, 1'b0);
    dbus.Ready = 1'b1;
    #1;
    chk("rw_write", dbus.Write, 1);
    chk("rw_stall", stall, 0);
    chk("rw_be", dbus.ByteEnable, 4'b0100);
    tick();

    // LH signed from 0x202: upper half 0x8001.
    op(1'b1, 1'b0, MEMSIZE_H, 1'b1, 32'h202, 32'd0, 1'b1);
    #1;
    chk("lh_stall", stall, 1);
    chk("lh_write", dbus.Write, 0);
    tick();
    chk("lh_bubble", wb_o.RegWrite, 0);
    dbus.Ready  = 1'b0;
    dbus.RValid = 1'b1;
    dbus.RData  = 32'h8001FFFF;
    #1;
    chk("lh_done_stall", stall, 0);
    chk("lh_wait_valid", dbus.Valid, 0);
    tick();
    dbus.RValid = 1'b0;
    chk("lh_data", mdata_o, 32'hFFFF8001);
    chk("lh_regwrite", wb_o.RegWrite, 1);
    chk("lh_alu", alu_o, 32'h202);

    // LHU, same response.
    op(1'b1, 1'b0, MEMSIZE_H, 1'b0, 32'h202, 32'd0, 1'b1);
    dbus.Ready = 1'b1;
    tick();
    dbus.Ready  = 1'b0;
    dbus.RValid = 1'b1;
    tick();
    dbus.RValid = 1'b0;
    chk("lhu_data", mdata_o, 32'h00008001);

    // LB signed from byte 1 of 0x00008000.
    op(1'b1, 1'b0, MEMSIZE_B, 1'b1, 32'h1, 32'd0, 1'b1);
    dbus.Ready = 1'b1;
    tick();
    dbus.Ready  = 1'b0;
    dbus.RValid = 1'b1;
    dbus.RData  = 32'h00008000;
    tick();
    dbus.RValid = 1'b0;
    chk("lb_data", mdata_o, 32'hFFFFFF80);

    // LW: Ready low for the issue cycle plus three REQ cycles, RValid two cycles after acceptance.
    op(1'b1, 1'b0, MEMSIZE_W, 1'b0, 32'h400, 32'd0, 1'b1);
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (stall) stalls++;
      chk("lw_req_valid", dbus.Valid, 1);
      chk("lw_req_addr", dbus.Addr, 32'h400);
      tick();
      chk("lw_req_bubble", wb_o.RegWrite, 0);
    end
    dbus.Ready = 1'b1;
    #1;
    if (stall) stalls++;
    chk("lw_acc_valid", dbus.Valid, 1);
    tick();
    dbus.Ready = 1'b0;
    #1;
    if (stall) stalls++;
    tick();
    chk("lw_wait_bubble", wb_o.RegWrite, 0);
    dbus.RValid = 1'b1;
    dbus.RData  = 32'hCAFEBABE;
    #1;
    if (stall) stalls++;
    chk("lw_stall_cycles", stalls, 6);
    tick();
    dbus.RValid = 1'b0;
    chk("lw_data", mdata_o, 32'hCAFEBABE);
    chk("lw_regwrite", wb_o.RegWrite, 1);

    // LW with no response: bus error after four WAIT_RD cycles.
    op(1'b1, 1'b0, MEMSIZE_W, 1'b0, 32'h500, 32'd0, 1'b1);
    dbus.Ready = 1'b1;
    tick();
    dbus.Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("to_stall", stall, 1);
      chk("to_berr_low", berr, 0);
      tick();
    end
    #1;
    chk("to_done_stall", stall, 0);
    tick();
    chk("to_berr", berr, 1);
    chk("to_memdata", mdata_o, 0);
    nop(32'h77, 1'b1);
    #1;
    chk("to_idle_stall", stall, 0);
    tick();
    chk("to_berr_pulse", berr, 0);
    chk("to_next_alu", alu_o, 32'h77);

    // Reset while waiting for read data; the late response is dropped.
    op(1'b1, 1'b0, MEMSIZE_W, 1'b0, 32'h600, 32'd0, 1'b1);
    dbus.Ready = 1'b1;
    tick();
    dbus.Ready = 1'b0;
    rst = 1'b1;
    nop(32'd0, 1'b0);
    #1;
    chk("mrst_valid", dbus.Valid, 0);
    tick();
    rst = 1'b0;
    chk("mrst_regwrite", wb_o.RegWrite, 0);
    chk("mrst_alu", alu_o, 0);
    tick();
    dbus.RValid = 1'b1;
    dbus.RData  = 32'h12345678;
    #1;
    chk("mrst_stray_stall", stall, 0);
    tick();
    dbus.RValid = 1'b0;
    chk("mrst_memdata", mdata_o, 0);
    chk("mrst_regwrite2", wb_o.RegWrite, 0);

`ifdef MEM_MISALIGN_TRAP_EN
    op(1'b1, 1'b0, MEMSIZE_W, 1'b0, 32'h301, 32'd0, 1'b1);
    dbus.Ready = 1'b1;
    #1;
    chk("mis_valid", dbus.Valid, 0);
    chk("mis_stall", stall, 0);
    tick();
    dbus.Ready = 1'b0;
    chk("mis_fault", mfault, 1);
    chk("mis_regwrite", wb_o.RegWrite, 0);
    nop(32'h9, 1'b1);
    tick();
    chk("mis_fault_pulse", mfault, 0);
`else
    // Low address bits are ignored for a word: lane 0 of the aligned word.
    op(1'b1, 1'b0, MEMSIZE_W, 1'b0, 32'h301, 32'd0, 1'b1);
    dbus.Ready = 1'b1;
    #1;
    chk("mis_addr", dbus.Addr, 32'h300);
    chk("mis_be", dbus.ByteEnable, 4'hF);
    tick();
    dbus.Ready  = 1'b0;
    dbus.RValid = 1'b1;
    dbus.RData  = 32'h11223344;
    tick();
    dbus.RValid = 1'b0;
    chk("mis_data", mdata_o, 32'h11223344);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- MEM stage of the in-order RV32I pipeline; consumes the EX/MEM pipeline register (control bundles, register IDs, ALU result, rs2 value).
- Issues loads and stores on a valid/ready data bus, aligns and extends load data, drives the MEM/WB pipeline register.
- Asserts o_Stall back to the pipeline while an access is outstanding.

Parameters:
- DBUS_TIMEOUT, 255: max cycles waiting for i_DBus_Ready or i_DBus_RValid before a bus error is declared; width = $clog2(DBUS_TIMEOUT+1).

Ports:
- i_Clock  in  1  clock
- i_Reset  in  1  synchronous, active-high reset
- i_MEM_Control  in  MEM_Control_t  MemRead, MemWrite, MemSize[1:0] (0=B, 1=H, 2=W), MemSignExtend
- i_WB_Control  in  WB_Control_t  passed to WB
- i_RegisterIDs  in  RegisterIDs_t  passed to WB
- i_AluOutput  in  32  effective address or ALU result
- i_rs2Value  in  32  store data
- o_WB_Control  out  WB_Control_t  registered
- o_RegisterIDs  out  RegisterIDs_t  registered
- o_AluOutput  out  32  registered ALU result
- o_MemData  out  32  registered, aligned and extended load data
- o_Stall  out  1  combinational; upstream holds all inputs stable while high
- o_BusError  out  1  registered one-cycle pulse on timeout
- o_DBus_Valid  out  1  request valid
- o_DBus_Write  out  1  1=store, 0=load
- o_DBus_Addr  out  32  word-aligned address {i_AluOutput[31:2],2'b00}
- o_DBus_WData  out  32  lane-replicated store data
- o_DBus_ByteEnable  out  4  active lanes
- i_DBus_Ready  in  1  request accepted when Valid&Ready
- i_DBus_RValid  in  1  read data valid (one beat per accepted load)
- i_DBus_RData  in  32  read data

Behaviour:
- Reset: state IDLE, timeout counter 0, o_DBus_Valid 0, o_WB_Control.RegWrite 0, o_BusError 0, o_MemData 0, o_AluOutput 0.
- States: IDLE, REQ (Valid high, waiting for Ready), WAIT_RD (load accepted, waiting for RValid).
- IDLE, no mem op: no stall; inputs register to the outputs at the next edge (1-cycle latency).
- IDLE, mem op: o_DBus_Valid asserted combinationally in the same cycle.
  - Store with Ready high: completes that cycle, no stall.
  - Store with Ready low: stall, go to REQ.
  - Load with Ready high: stall, go to WAIT_RD.
  - Load with Ready low: stall, go to REQ.
- REQ: Valid held with all bus fields stable until Ready. On Ready, a store completes (o_Stall low that cycle, return to IDLE) and a load goes to WAIT_RD.
- WAIT_RD: on RValid, o_Stall low, extracted data latched into o_MemData, return to IDLE. Minimum load latency is 2 cycles (1 stall).
- A load response arriving in IDLE or REQ is dropped.
- Stall cycles: o_WB_Control.RegWrite registered 0 (bubble); other outputs hold.
- Completion cycle: all pipeline outputs latch from the inputs.
- Store lanes:
  - B: WData={4{rs2[7:0]}}, ByteEnable=1<<a[1:0]
  - H: WData={2{rs2[15:0]}}, ByteEnable=a[1]?4'b1100:4'b0011
  - W: WData=rs2, ByteEnable=4'b1111
- Load extract: shift RData right by 8*a[1:0] (H uses a[1] only); sign- or zero-extend per MemSignExtend; W passes RData unchanged.
- Timeout: counter clears on entering REQ/WAIT_RD and increments each cycle in those states.
  - When it reaches DBUS_TIMEOUT: pulse o_BusError, complete the op with o_MemData=0, return to IDLE.
- MemRead and MemWrite both high: treated as store.
- Reset mid-operation: immediate IDLE; Valid drops the same cycle reset is sampled; a later stray RValid is ignored.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - H with a[0]=1, or W with a[1:0]!=0, issues no bus request and asserts no stall.
  - Adds output o_MisalignFault: registered one-cycle pulse.
  - Forces o_WB_Control.RegWrite=0 for that instruction.
- Undefined: misaligned low bits are ignored (H uses a[1], W uses lane 0); no fault port.

Decomposition:
- pipeline_signals.svh (shared): MEM_Control_t gains MemSize and MemSignExtend; MEMSIZE_B/H/W constants.
- stage_memory.svh: FSM state enum MEMSTATE_IDLE/REQ/WAIT_RD.
- Sub-module mem_align (combinational): store lane replication and byte enables, load extraction and extension; unit-testable alone.

Test Plan:
- ALU op, AluOutput=0x1234, RegWrite=1 -> next cycle o_AluOutput=0x1234, RegWrite=1, o_Stall never high.
- SB addr 0x103, rs2=0xAB, Ready=1 -> same cycle WData=0xABABABAB, ByteEnable=4'b1000, Addr=0x100, no stall.
- LH signed addr 0x202, Ready=1, RValid next cycle with RData=0x8001FFFF -> one stall cycle, o_MemData=0xFFFF8001. LHU with the same data -> 0x00008001.
- LW with Ready low for 3 cycles, then RValid 2 cycles after acceptance -> o_Stall high 6 cycles, bubble RegWrite=0 each stall cycle, Valid/Addr stable throughout REQ.
- LW with Ready=1, RValid never, DBUS_TIMEOUT=4 -> o_BusError pulses after 4 WAIT_RD cycles, o_MemData=0, state IDLE, next instruction proceeds.
- Reset asserted in WAIT_RD, RValid two cycles later -> Valid 0, RegWrite 0, RValid ignored. With MEM_MISALIGN_TRAP_EN, LW addr 0x301 -> o_MisalignFault pulse, no Valid, RegWrite 0.
